// File: rtl/solix_pkg.sv
// Shared definitions for the Solix-16 word serializer.
//
// Contents:
//   ser_state_t  - serializer FSM state (SER_IDLE, SER_SHIFT)
//   ser_cnt_w()  - width of the bit counter for a given word width
//   SER_CNT_W    - counter width for the default 16-bit datapath
//
// The counter is sized from WIDTH+2 so that a frame carrying an optional
// parity bit (WIDTH+1 beats) still fits, with one code point of headroom.
package solix_pkg;

   typedef enum logic {
      SER_IDLE,
      SER_SHIFT
   } ser_state_t;

   function automatic int ser_cnt_w(input int width);
      return $clog2(width + 2);
   endfunction

   localparam int SER_CNT_W = ser_cnt_w(16);

endpackage

// File: rtl/ser_bit_counter.sv
// Beat counter for the word serializer.
//
// Parameters:
//   FL     frame length in beats (counter runs 0 .. FL-1 and saturates there)
//   CNT_W  counter width
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   synchronous reset, active low
//   clr      in   return count to zero (new word loaded or frame finished)
//   inc      in   advance count by one (serial beat)
//   count    out  current bit index within the frame
//   is_last  out  count is on the final bit of the frame
module ser_bit_counter #(
   parameter int FL    = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             is_last
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FL - 1);

   assign is_last = (count == LAST_CNT);

   // Clear has priority over increment so a new word arriving on the final
   // beat starts at bit zero. The count saturates at the last index.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !is_last) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/word_serializer.sv
// Parallel-in / serial-out transmitter for Solix-16 datapath words.
//
// A WIDTH-bit word is taken over a valid/ready handshake and sent one bit
// per accepted beat on a valid/ready serial port. A new word may be taken on
// the final beat of the current frame, so back-to-back frames have no gap.
//
// Parameters:
//   WIDTH      data word width in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous reset, active low
//   in_valid   in   upstream word valid
//   in_ready   out  word can be accepted this cycle (combinational)
//   in_data    in   parallel word, sampled when in_valid & in_ready
//   ser_valid  out  ser_out holds a valid bit
//   ser_ready  in   downstream accepts the bit
//   ser_out    out  current serial bit
//   ser_last   out  current bit is the final bit of the frame
// Configuration:
//   SERIALIZER_PARITY_EN  when defined, an even-parity bit (XOR of the word)
//                         follows the data bits and carries ser_last.
module word_serializer
   import solix_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             ser_out,
   output logic             ser_last
);

`ifdef SERIALIZER_PARITY_EN
   localparam int FL = WIDTH + 1;
`else
   localparam int FL = WIDTH;
`endif

   localparam int               CNT_W        = ser_cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(FL - 2);

   ser_state_t       state;
   ser_state_t       state_nxt;
   logic [FL-1:0]    shift_q;
   logic [FL-1:0]    load_val;
   logic [CNT_W-1:0] count;
   logic             is_last;
   logic             beat;
   logic             final_beat;
   logic             accept;

   // Beat counter: restarts on every load and when a frame closes.
   ser_bit_counter #(
      .FL    (FL),
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (accept | final_beat),
      .inc     (beat),
      .count   (count),
      .is_last (is_last)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= SER_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake decode. in_ready is gated by rst_n so nothing
   // is accepted while reset is held. In SHIFT the port opens only on the
   // final beat, which lets the next word follow without a bubble.
   always_comb begin
      state_nxt  = state;
      in_ready   = 1'b0;
      beat       = 1'b0;
      final_beat = 1'b0;
      case (state)
         SER_IDLE: begin
            in_ready = rst_n;
            if (in_valid && rst_n) begin
               state_nxt = SER_SHIFT;
            end
         end
         SER_SHIFT: begin
            beat = ser_ready;
            if (ser_ready && is_last) begin
               final_beat = 1'b1;
               in_ready   = rst_n;
               if (!in_valid) begin
                  state_nxt = SER_IDLE;
               end
            end
         end
         default: state_nxt = SER_IDLE;
      endcase
      accept = in_valid & in_ready;
   end

   // Frame image placed in the shift register. The parity bit sits just
   // behind the data bits at the far end from the output.
   always_comb begin
      load_val = '0;
`ifdef SERIALIZER_PARITY_EN
      if (MSB_FIRST) begin
         load_val = {in_data, ^in_data};
      end else begin
         load_val = {^in_data, in_data};
      end
`else
      load_val = in_data;
`endif
   end

   // Shift register: the output end is bit FL-1 for MSB-first and bit 0
   // otherwise. Zeros shift in, so ser_out returns to 0 once a frame drains.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shift_q <= '0;
      end else if (accept) begin
         shift_q <= load_val;
      end else if (beat) begin
         if (MSB_FIRST) begin
            shift_q <= shift_q << 1;
         end else begin
            shift_q <= shift_q >> 1;
         end
      end
   end

   // ser_last is registered one cycle ahead: it rises on the beat that moves
   // the counter onto the final index and drops on any load or frame end.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ser_last <= 1'b0;
      end else if (accept) begin
         ser_last <= 1'b0;
      end else if (beat) begin
         ser_last <= (count == PRE_LAST_CNT);
      end
   end

   assign ser_valid = (state == SER_SHIFT);
   assign ser_out   = MSB_FIRST ? shift_q[FL-1] : shift_q[0];

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer.
//
// Two instances share clock, reset, data and ser_ready: one MSB-first, one
// LSB-first, each with its own in_valid. The expected serial stream is a
// queue of bits built from each accepted word; every cycle the bench compares
// handshake and serial outputs against that queue.
// Honours SERIALIZER_PARITY_EN (adds the parity bit to the expected frame).
module tb_word_serializer;

   localparam int W = 16;
`ifdef SERIALIZER_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         ser_ready = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_valid_m = 1'b0;
   logic         in_valid_l = 1'b0;
   logic         in_ready_m, ser_valid_m, ser_out_m, ser_last_m;
   logic         in_ready_l, ser_valid_l, ser_out_l, ser_last_l;

   always #5 clk = ~clk;

   word_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_m),
      .in_ready  (in_ready_m),
      .in_data   (in_data),
      .ser_valid (ser_valid_m),
      .ser_ready (ser_ready),
      .ser_out   (ser_out_m),
      .ser_last  (ser_last_m)
   );

   word_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_l),
      .in_ready  (in_ready_l),
      .in_data   (in_data),
      .ser_valid (ser_valid_l),
      .ser_ready (ser_ready),
      .ser_out   (ser_out_l),
      .ser_last  (ser_last_l)
   );

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] word_q[$];
   logic         exp_q[$];

   // Single comparison point.
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected serial frame for one word.
   task automatic pushFrame(input logic [W-1:0] w, input bit msb);
      for (int i = 0; i < W; i++) begin
         exp_q.push_back(msb ? w[W-1-i] : w[i]);
      end
`ifdef SERIALIZER_PARITY_EN
      exp_q.push_back(^w);
`endif
   endtask

   // Streams every word in word_q through one instance.
   // bp_mode: 0 = ser_ready always 1, 1 = pattern 1,0,0,..., 2 = random.
   // abort_after > 0 pulses reset once that many beats have gone out.
   task automatic applyStimulus(input bit lsb, input int bp_mode,
                                input int abort_after);
      int   beats;
      int   cyc;
      int   nwords;
      logic v, o, l, r, rdy_exp;
      beats  = 0;
      cyc    = 0;
      nwords = word_q.size();
      exp_q.delete();
      while ((word_q.size() > 0 || exp_q.size() > 0) && cyc < 3000) begin
         @(negedge clk);
         if (abort_after > 0 && beats == abort_after) begin
            rst_n      = 1'b0;
            in_valid_m = 1'b0;
            in_valid_l = 1'b0;
            ser_ready  = 1'b1;
            #1;
            checkOutput("rst_in_ready", lsb ? in_ready_l : in_ready_m, 1'b0);
            @(negedge clk);
            checkOutput("abort_valid", lsb ? ser_valid_l : ser_valid_m, 1'b0);
            checkOutput("abort_last", lsb ? ser_last_l : ser_last_m, 1'b0);
            checkOutput("abort_out", lsb ? ser_out_l : ser_out_m, 1'b0);
            rst_n = 1'b1;
            exp_q.delete();
            word_q.delete();
            return;
         end
         in_valid_m = 1'b0;
         in_valid_l = 1'b0;
         if (word_q.size() > 0) begin
            in_data = word_q[0];
            if (lsb) in_valid_l = 1'b1;
            else     in_valid_m = 1'b1;
         end else begin
            in_data = W'($urandom);
         end
         case (bp_mode)
            0:       ser_ready = 1'b1;
            1:       ser_ready = (cyc % 3 == 0);
            default: ser_ready = 1'($urandom);
         endcase
         #1;
         v = lsb ? ser_valid_l : ser_valid_m;
         o = lsb ? ser_out_l   : ser_out_m;
         l = lsb ? ser_last_l  : ser_last_m;
         r = lsb ? in_ready_l  : in_ready_m;
         rdy_exp = (exp_q.size() == 0) || (exp_q.size() == 1 && ser_ready);
         checkOutput("in_ready", r, rdy_exp);
         checkOutput("ser_valid", v, exp_q.size() > 0);
         if (exp_q.size() > 0) begin
            checkOutput("ser_out", o, exp_q[0]);
            checkOutput("ser_last", l, exp_q.size() == 1);
            if (ser_ready) begin
               void'(exp_q.pop_front());
               beats++;
            end
         end
         if (word_q.size() > 0 && rdy_exp) begin
            pushFrame(word_q.pop_front(), !lsb);
         end
         cyc++;
      end
      checkOutput("timeout", (word_q.size() == 0 && exp_q.size() == 0), 1'b1);
      checkOutput("beats", beats, nwords * FL);
      @(negedge clk);
      in_valid_m = 1'b0;
      in_valid_l = 1'b0;
      #1;
      checkOutput("idle_valid", lsb ? ser_valid_l : ser_valid_m, 1'b0);
      checkOutput("idle_ready", lsb ? in_ready_l : in_ready_m, 1'b1);
      checkOutput("idle_out", lsb ? ser_out_l : ser_out_m, 1'b0);
   endtask

   initial begin
      // Reset held for two cycles.
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_valid_m", ser_valid_m, 1'b0);
      checkOutput("rst_out_m", ser_out_m, 1'b0);
      checkOutput("rst_last_m", ser_last_m, 1'b0);
      checkOutput("rst_ready_m", in_ready_m, 1'b0);
      checkOutput("rst_ready_l", in_ready_l, 1'b0);
      rst_n = 1'b1;
      #1;
      checkOutput("rel_ready_m", in_ready_m, 1'b1);
      checkOutput("rel_ready_l", in_ready_l, 1'b1);

      // Single word, no backpressure.
      word_q.push_back(16'hA5C3);
      applyStimulus(1'b0, 0, 0);

      // Back-to-back words with in_valid held high.
      word_q.push_back(16'hFFFF);
      word_q.push_back(16'h0001);
      applyStimulus(1'b0, 0, 0);

      // Backpressure pattern 1,0,0,1,...
      word_q.push_back(16'h8001);
      applyStimulus(1'b0, 1, 0);

      // Reset after beat 7, then a full fresh frame.
      word_q.push_back(16'h1234);
      applyStimulus(1'b0, 0, 7);
      word_q.push_back(16'h00FF);
      applyStimulus(1'b0, 0, 0);

      // Parity-sensitive words and LSB-first ordering.
      word_q.push_back(16'h0007);
      word_q.push_back(16'h0003);
      applyStimulus(1'b0, 0, 0);
      word_q.push_back(16'h0001);
      applyStimulus(1'b1, 0, 0);

      // Random words with random backpressure on both instances.
      for (int k = 0; k < 4; k++) word_q.push_back(W'($urandom));
      applyStimulus(1'b0, 2, 0);
      for (int k = 0; k < 4; k++) word_q.push_back(W'($urandom));
      applyStimulus(1'b1, 2, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
